wb_arb_n: RTL

N-master Wishbone arbiter/multiplexer that merges `NUM_MASTERS` master ports onto a single Wishbone slave-side bus. It sits between the CPU instruction/data ports, the debug/DMA masters and the shared memory/peripheral fabric. It is selectable between fixed-priority and round-robin arbitration. Grant is held for the owner's whole `cyc` assertion (bursts and locked sequences), not just a single ACK, and an optional bus-timeout watchdog can be compiled in.

---
 rtl/wb_arb_n.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wb_arb_n.sv
// N-master Wishbone arbiter/mux, fixed-priority or round-robin, grant held for the owner's whole cyc.
// Optional bus-timeout watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_arb_n #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ROUND_ROBIN    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                sys_clk,
    input  logic                                resetcpu,
    input  logic [NUM_MASTERS-1:0]              s_cyc,
    input  logic [NUM_MASTERS-1:0]              s_stb,
    input  logic [NUM_MASTERS-1:0]              s_we,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   s_sel,
    input  logic [NUM_MASTERS*ADDR_W-1:0]       s_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0]       s_dat_o,
    output logic [DATA_W-1:0]                   s_dat_i,
    output logic [NUM_MASTERS-1:0]              s_ack,
    output logic [NUM_MASTERS-1:0]              s_err,
    output logic                                m_cyc,
    output logic                                m_stb,
    output logic                                m_we,
    output logic [DATA_W/8-1:0]                 m_sel,
    output logic [ADDR_W-1:0]                   m_adr,
    output logic [DATA_W-1:0]                   m_dat_o,
    input  logic [DATA_W-1:0]                   m_dat_i,
    input  logic                                m_ack,
    input  logic                                m_err,
    output logic [NUM_MASTERS-1:0]              grant
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state;
    logic [IDX_W-1:0] own;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             win_found;
    logic             owner_cyc;

    // Search order starts at last+1 in round-robin mode, at 0 in fixed mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (ROUND_ROBIN != 0)
                cand = IDX_W'((int'(last) + 1 + k) % NUM_MASTERS);
            else
                cand = IDX_W'(k);
            if (!win_found && s_cyc[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_cyc = |(grant & s_cyc);

    always_ff @(posedge sys_clk or posedge resetcpu) begin
        if (resetcpu) begin
            state <= IDLE;
            grant <= '0;
            own   <= '0;
            last  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant <= NUM_MASTERS'(1) << win_idx;
                        own   <= win_idx;
                        state <= OWNED;
                    end
                end
                OWNED: begin
                    if (!owner_cyc) begin
                        grant <= '0;
                        last  <= own;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Mux driven straight off the registered grant so an async reset zeroes it at once.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_sel   = '0;
        m_adr   = '0;
        m_dat_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                m_cyc   = s_cyc[i];
                m_stb   = s_stb[i];
                m_we    = s_we[i];
                m_sel   = s_sel[i*SEL_W +: SEL_W];
                m_adr   = s_adr[i*ADDR_W +: ADDR_W];
                m_dat_o = s_dat_o[i*DATA_W +: DATA_W];
            end
        end
    end

    assign s_dat_i = m_dat_i;
    assign s_ack   = grant & {NUM_MASTERS{m_ack}};

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt;
    logic        wd_active;
    logic        wd_fire;

    assign wd_active = m_cyc & m_stb & ~m_ack & ~m_err;
    assign wd_fire   = wd_active && (wd_cnt == WD_LIMIT);

    always_ff @(posedge sys_clk or posedge resetcpu) begin
        if (resetcpu)
            wd_cnt <= '0;
        else if (!wd_active || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end

    assign s_err = grant & {NUM_MASTERS{m_err | wd_fire}};
`else
    assign s_err = grant & {NUM_MASTERS{m_err}};
`endif

endmodule
